// File: rtl/mac_cfg_seq_if.sv
// mac_cfg_seq_if -- AXI4-Lite write channel bundle (AW, W, B) for mac_cfg_seq.
// Rev 1.0
`default_nettype none

interface mac_cfg_seq_if;
  logic [31:0] S_AXI_awaddr;
  logic        S_AXI_awvalid;
  logic        S_AXI_awready;
  logic [31:0] S_AXI_wdata;
  logic        S_AXI_wvalid;
  logic        S_AXI_wready;
  logic [1:0]  S_AXI_bresp;
  logic        S_AXI_bvalid;
  logic        S_AXI_bready;

  modport master (
    output S_AXI_awaddr, S_AXI_awvalid, S_AXI_wdata, S_AXI_wvalid, S_AXI_bready,
    input  S_AXI_awready, S_AXI_wready, S_AXI_bresp, S_AXI_bvalid
  );

  modport slave (
    input  S_AXI_awaddr, S_AXI_awvalid, S_AXI_wdata, S_AXI_wvalid, S_AXI_bready,
    output S_AXI_awready, S_AXI_wready, S_AXI_bresp, S_AXI_bvalid
  );
endinterface

`default_nettype wire

// File: rtl/mac_cfg_seq.sv
// mac_cfg_seq -- walks a configuration table and issues one AXI4-Lite write per entry.
// Rev 1.0
`default_nettype none

module mac_cfg_seq #(
  parameter int N_ENTRIES = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic                Clk_reg,
  input  logic                ResetB,
  input  logic                Start,
  output logic [7:0]          Tbl_addr,
  input  logic [63:0]         Tbl_data,
  mac_cfg_seq_if.master       axi,
  output logic                Busy,
  output logic                CPU_init_end,
  output logic                Err,
  output logic [7:0]          Err_idx
);

  localparam int                CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [7:0]        LAST_IDX = 8'(N_ENTRIES - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       err_idx_q, err_idx_d;
  logic [31:0]      awaddr_q, awaddr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             awvalid_q, awvalid_d;
  logic             wvalid_q, wvalid_d;
  logic             aw_done_q, aw_done_d;
  logic             w_done_q, w_done_d;
  logic             init_end_q, init_end_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_hit;

  // The counter value seen in the Nth WRITE/RESP cycle is N-1.
  assign timeout_hit = ((state_q == WRITE) || (state_q == RESP)) && (cnt_q == CNT_LAST);

  always_ff @(posedge Clk_reg or negedge ResetB) begin
    if (!ResetB) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      err_idx_q  <= '0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      init_end_q <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      err_idx_q  <= err_idx_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      init_end_q <= init_end_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    err_idx_d  = err_idx_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    init_end_d = init_end_q;
    err_d      = err_q;
    cnt_d      = cnt_q;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (Start) begin
          state_d    = FETCH;
          addr_d     = '0;
          init_end_d = 1'b0;
          err_d      = 1'b0;
        end
      end
      FETCH: begin
        cnt_d   = '0;
        state_d = LOAD;
      end
      LOAD: begin
        awaddr_d  = Tbl_data[63:32];
        wdata_d   = Tbl_data[31:0];
        awvalid_d = 1'b1;
        wvalid_d  = 1'b1;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        state_d   = WRITE;
      end
      WRITE: begin
        cnt_d = cnt_q + 1'b1;
        if (awvalid_q && axi.S_AXI_awready) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && axi.S_AXI_wready) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_done_q && w_done_q) begin
          state_d = RESP;
        end
        if (timeout_hit) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          err_d     = 1'b1;
          err_idx_d = addr_q;
          state_d   = ERR;
        end
      end
      RESP: begin
        cnt_d = cnt_q + 1'b1;
        if (axi.S_AXI_bvalid) begin
          if (axi.S_AXI_bresp != 2'b00) begin
            err_d     = 1'b1;
            err_idx_d = addr_q;
            state_d   = ERR;
          end else if (addr_q == LAST_IDX) begin
            init_end_d = 1'b1;
            state_d    = DONE;
          end else begin
            addr_d  = addr_q + 8'd1;
            state_d = FETCH;
          end
        end else if (timeout_hit) begin
          err_d     = 1'b1;
          err_idx_d = addr_q;
          state_d   = ERR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Tbl_addr          = addr_q;
  assign Err_idx           = err_idx_q;
  assign CPU_init_end      = init_end_q;
  assign Err               = err_q;
  assign Busy              = (state_q == FETCH) || (state_q == LOAD) ||
                             (state_q == WRITE) || (state_q == RESP);
  assign axi.S_AXI_awaddr  = awaddr_q;
  assign axi.S_AXI_awvalid = awvalid_q;
  assign axi.S_AXI_wdata   = wdata_q;
  assign axi.S_AXI_wvalid  = wvalid_q;
  assign axi.S_AXI_bready  = (state_q == RESP);

endmodule

`default_nettype wire

// File: tb/tb_mac_cfg_seq.sv
// tb_mac_cfg_seq -- directed bench: configurable AXI4-Lite slave, table-driven passes, corner sequences.
// Rev 1.0
`default_nettype none

module tb_mac_cfg_seq;
  localparam int N  = 4;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  tbl_addr;
  logic [7:0]  err_idx;
  logic [63:0] tbl_data;
  logic        busy, init_end, err;

  int checks = 0;
  int errors = 0;

  mac_cfg_seq_if axi ();

  mac_cfg_seq #(.N_ENTRIES(N), .TIMEOUT(TO)) dut (
    .Clk_reg      (clk),
    .ResetB       (rst_n),
    .Start        (start),
    .Tbl_addr     (tbl_addr),
    .Tbl_data     (tbl_data),
    .axi          (axi.master),
    .Busy         (busy),
    .CPU_init_end (init_end),
    .Err          (err),
    .Err_idx      (err_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] exp_addr(input int i);
    return 32'h4000_0010 + 32'(i) * 32'h10;
  endfunction

  function automatic logic [31:0] exp_data(input int i);
    return 32'hDEAD_0000 + 32'(i);
  endfunction

  // Synchronous table memory: data valid one cycle after the index.
  always @(posedge clk) tbl_data <= {exp_addr(int'(tbl_addr)), exp_data(int'(tbl_addr))};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave behaviour knobs and beat counters
  int aw_dly = 0, w_dly = 0, b_dly = 0, err_entry = -1;
  bit b_never = 1'b0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  int aw_beats = 0, w_beats = 0, b_beats = 0;

  initial begin
    axi.S_AXI_awready = 1'b0;
    axi.S_AXI_wready  = 1'b0;
    axi.S_AXI_bvalid  = 1'b0;
    axi.S_AXI_bresp   = 2'b00;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      axi.S_AXI_awready = 1'b0;
      axi.S_AXI_wready  = 1'b0;
      axi.S_AXI_bvalid  = 1'b0;
      axi.S_AXI_bresp   = 2'b00;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    end else begin
      if (!axi.S_AXI_awvalid) begin
        axi.S_AXI_awready = 1'b0; aw_cnt = 0;
      end else if (!axi.S_AXI_awready) begin
        if (aw_cnt >= aw_dly) axi.S_AXI_awready = 1'b1; else aw_cnt++;
      end
      if (!axi.S_AXI_wvalid) begin
        axi.S_AXI_wready = 1'b0; w_cnt = 0;
      end else if (!axi.S_AXI_wready) begin
        if (w_cnt >= w_dly) axi.S_AXI_wready = 1'b1; else w_cnt++;
      end
      if (!axi.S_AXI_bready) begin
        axi.S_AXI_bvalid = 1'b0; axi.S_AXI_bresp = 2'b00; b_cnt = 0;
      end else if (!axi.S_AXI_bvalid && !b_never) begin
        if (b_cnt >= b_dly) begin
          axi.S_AXI_bvalid = 1'b1;
          axi.S_AXI_bresp  = ((aw_beats - 1) == err_entry) ? 2'b10 : 2'b00;
        end else b_cnt++;
      end
    end
  end

  // Beat monitor: every accepted beat must carry the next table entry in order.
  logic        prev_awv = 1'b0, prev_awr = 1'b0, prev_wv = 1'b0, prev_wr = 1'b0;
  logic [31:0] prev_awaddr = '0, prev_wdata = '0;
  always @(posedge clk) begin
    if (rst_n) begin
      if (prev_awv && !prev_awr && axi.S_AXI_awvalid)
        chk("awaddr_stable", 64'(axi.S_AXI_awaddr), 64'(prev_awaddr));
      if (prev_wv && !prev_wr && axi.S_AXI_wvalid)
        chk("wdata_stable", 64'(axi.S_AXI_wdata), 64'(prev_wdata));
      if (axi.S_AXI_awvalid && axi.S_AXI_awready) begin
        chk($sformatf("aw_beat%0d_addr", aw_beats), 64'(axi.S_AXI_awaddr), 64'(exp_addr(aw_beats)));
        aw_beats++;
      end
      if (axi.S_AXI_wvalid && axi.S_AXI_wready) begin
        chk($sformatf("w_beat%0d_data", w_beats), 64'(axi.S_AXI_wdata), 64'(exp_data(w_beats)));
        w_beats++;
      end
      if (axi.S_AXI_bvalid && axi.S_AXI_bready) b_beats++;
    end
    prev_awv    = axi.S_AXI_awvalid;
    prev_awr    = axi.S_AXI_awready;
    prev_awaddr = axi.S_AXI_awaddr;
    prev_wv     = axi.S_AXI_wvalid;
    prev_wr     = axi.S_AXI_wready;
    prev_wdata  = axi.S_AXI_wdata;
  end

  typedef struct {
    int aw_dly;
    int w_dly;
    int b_dly;
    int err_entry;
    bit spam;
    bit exp_done;
    bit exp_err;
    int exp_err_idx;
    int exp_beats;
    int exp_cycles;
  } vec_t;

  task automatic clear_beats();
    aw_beats = 0; w_beats = 0; b_beats = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int cyc;
    aw_dly = v.aw_dly; w_dly = v.w_dly; b_dly = v.b_dly;
    err_entry = v.err_entry; b_never = 1'b0;
    clear_beats();
    pulse_start();
    chk($sformatf("v%0d_start_busy", n), 64'(busy), 64'(1));
    chk($sformatf("v%0d_start_idx", n), 64'(tbl_addr), 64'(0));
    chk($sformatf("v%0d_start_flags", n), 64'({init_end, err}), 64'(0));
    cyc = 0;
    while (cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (init_end || err) break;
      start = v.spam && cyc[0];
    end
    start = 1'b0;
    chk($sformatf("v%0d_cycles", n), 64'(cyc), 64'(v.exp_cycles));
    chk($sformatf("v%0d_done", n), 64'(init_end), 64'(v.exp_done));
    chk($sformatf("v%0d_err", n), 64'(err), 64'(v.exp_err));
    chk($sformatf("v%0d_idle_outs", n),
        64'({busy, axi.S_AXI_awvalid, axi.S_AXI_wvalid, axi.S_AXI_bready}), 64'(0));
    chk($sformatf("v%0d_aw_beats", n), 64'(aw_beats), 64'(v.exp_beats));
    chk($sformatf("v%0d_w_beats", n), 64'(w_beats), 64'(v.exp_beats));
    chk($sformatf("v%0d_b_beats", n), 64'(b_beats), 64'(v.exp_beats));
    if (v.exp_err) chk($sformatf("v%0d_err_idx", n), 64'(err_idx), 64'(v.exp_err_idx));
    repeat (2) @(posedge clk);
  endtask

  vec_t vecs[7];

  initial begin
    int cyc;
    //           aw w  b  errE spam done err idx beats cycles
    vecs[0] = '{0, 0, 0, -1, 0, 1, 0, 0, 4, 20};
    vecs[1] = '{0, 0, 0, -1, 1, 1, 0, 0, 4, 20};
    vecs[2] = '{3, 0, 0, -1, 0, 1, 0, 0, 4, 32};
    vecs[3] = '{0, 2, 1, -1, 0, 1, 0, 0, 4, 32};
    vecs[4] = '{0, 0, 0,  2, 0, 0, 1, 2, 3, 15};
    vecs[5] = '{1, 1, 2,  0, 0, 0, 1, 0, 1, 8};
    vecs[6] = '{0, 0, 0, -1, 0, 1, 0, 0, 4, 20};

    // Asynchronous reset state, before any clock edge
    #2;
    chk("rst_flags", 64'({busy, init_end, err, axi.S_AXI_awvalid, axi.S_AXI_wvalid, axi.S_AXI_bready}), 64'(0));
    chk("rst_bus", 64'({axi.S_AXI_awaddr, axi.S_AXI_wdata}), 64'(0));
    chk("rst_idx", 64'({tbl_addr, err_idx}), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Timeout: bvalid never arrives
    aw_dly = 0; w_dly = 0; b_dly = 0; err_entry = -1; b_never = 1'b1;
    clear_beats();
    pulse_start();
    cyc = 0;
    while (!axi.S_AXI_awvalid && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    chk("to_write_entry", 64'(cyc), 64'(2));
    repeat (7) @(posedge clk);
    #1;
    chk("to_last_resp", 64'({busy, axi.S_AXI_bready, err}), 64'(3'b110));
    @(posedge clk); #1;
    chk("to_err_state", 64'({err, busy, init_end}), 64'(3'b100));
    chk("to_outs_low", 64'({axi.S_AXI_awvalid, axi.S_AXI_wvalid, axi.S_AXI_bready}), 64'(0));
    chk("to_err_idx", 64'(err_idx), 64'(0));
    b_never = 1'b0;
    repeat (2) @(posedge clk);

    // Reset in the middle of entry 1's write
    aw_dly = 3;
    clear_beats();
    pulse_start();
    cyc = 0;
    while (!(aw_beats == 1 && axi.S_AXI_awvalid) && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    chk("rst_mid_reach", 64'(tbl_addr), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_flags", 64'({busy, init_end, err, axi.S_AXI_awvalid, axi.S_AXI_wvalid, axi.S_AXI_bready}), 64'(0));
    chk("rst_mid_bus", 64'({axi.S_AXI_awaddr, axi.S_AXI_wdata}), 64'(0));
    chk("rst_mid_idx", 64'({tbl_addr, err_idx}), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_mid_wait_idle", 64'({busy, init_end, err}), 64'(0));
    chk("rst_mid_no_resp", 64'(b_beats), 64'(1));
    run_vec(vecs[0], 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mac_cfg_seq.md
MAC_CFG_SEQ -- requirements
Module: mac_cfg_seq

Interface
REQ-001 SHALL have parameter N_ENTRIES, default 16: number of configuration table entries, 1..256.
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum Clk_reg cycles allowed per AXI write transaction.
REQ-003 SHALL have port Clk_reg, input, 1: sole clock; all logic is rising-edge.
REQ-004 SHALL have port ResetB, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port Start, input, 1: single-cycle pulse that begins a configuration pass.
REQ-006 SHALL have port Tbl_addr, output, 8: configuration table entry index.
REQ-007 SHALL have port Tbl_data, input, 64: table entry, with [63:32] the register address and [31:0] the write data; valid one cycle after Tbl_addr.
REQ-008 SHALL have AXI4-Lite write-master ports:
- S_AXI_awaddr, output, 32
- S_AXI_awvalid, output, 1
- S_AXI_awready, input, 1
- S_AXI_wdata, output, 32
- S_AXI_wvalid, output, 1
- S_AXI_wready, input, 1
- S_AXI_bresp, input, 2
- S_AXI_bvalid, input, 1
- S_AXI_bready, output, 1
REQ-009 SHALL have port Busy, output, 1: a pass is in progress.
REQ-010 SHALL have port CPU_init_end, output, 1: the last pass completed without error; sticky.
REQ-011 SHALL have port Err, output, 1: the last pass aborted; sticky.
REQ-012 SHALL have port Err_idx, output, 8: index of the failing entry.

Function
REQ-013 SHALL implement the FSM states IDLE, FETCH, LOAD, WRITE, RESP, DONE, ERR.
REQ-014 IDLE: Start=1 -> FETCH, with Tbl_addr<=0, CPU_init_end<=0, Err<=0. Start is ignored in every state other than IDLE, DONE and ERR.
REQ-015 FETCH: drive Tbl_addr and wait one cycle -> LOAD.
REQ-016 LOAD: capture Tbl_data[63:32] into S_AXI_awaddr and Tbl_data[31:0] into S_AXI_wdata, then assert S_AXI_awvalid and S_AXI_wvalid -> WRITE.
REQ-017 WRITE: each valid SHALL drop the cycle after its own ready is sampled high; AW and W handshakes are independent and may complete in either order or together. When both have completed -> RESP.
REQ-018 S_AXI_awaddr and S_AXI_wdata SHALL be held stable while the corresponding valid is high.
REQ-019 RESP: S_AXI_bready=1. On S_AXI_bvalid=1:
- S_AXI_bresp=2'b00 and Tbl_addr=N_ENTRIES-1 -> DONE.
- S_AXI_bresp=2'b00 otherwise -> increment Tbl_addr, then FETCH.
- S_AXI_bresp!=2'b00 -> ERR, with Err_idx<=Tbl_addr.
REQ-020 S_AXI_bready SHALL be asserted only in RESP.
REQ-021 A per-transaction cycle counter SHALL clear on entry to LOAD and increment every cycle in WRITE and RESP. Reaching TIMEOUT before a B handshake SHALL go to ERR (Err_idx<=Tbl_addr) and deassert all valids and bready.
REQ-022 DONE: CPU_init_end=1, Busy=0. Start -> FETCH (re-run, clearing CPU_init_end).
REQ-023 ERR: Err=1, Busy=0. Start -> FETCH (retry from entry 0, clearing Err).
REQ-024 Busy SHALL be 1 exactly in FETCH, LOAD, WRITE and RESP.
REQ-025 Tbl_addr SHALL wrap nowhere: it never exceeds N_ENTRIES-1.
REQ-026 Best-case throughput, with ready and bvalid immediate, SHALL be one entry per 5 cycles.

Reset
REQ-027 ResetB=0 SHALL immediately force state IDLE and clear every output: valids, bready, Busy, CPU_init_end and Err =0; S_AXI_awaddr, S_AXI_wdata, Tbl_addr and Err_idx =0.
REQ-028 Reset asserted mid-transaction SHALL abandon the transaction with no completion; after release the block waits in IDLE for Start.

Verification
REQ-029 N_ENTRIES=4, slave always ready with OKAY, Start pulse -> 4 writes in table order with matching addr/data, CPU_init_end=1 at the 20th cycle after Start, Busy=0.
REQ-030 wready asserted 3 cycles before awready -> wvalid drops after the W handshake, awvalid is held, exactly one B response is accepted per entry, and no duplicate AW or W beats occur.
REQ-031 Slave returns bresp=2'b10 on entry 2 -> Err=1, Err_idx=2, CPU_init_end=0, and no write is issued for entry 3.
REQ-032 Slave never asserts bvalid, TIMEOUT=8 -> ERR entered 8 cycles after LOAD, with valids and bready =0.
REQ-033 ResetB pulsed low during WRITE of entry 1 -> all outputs 0 asynchronously; a new Start re-runs the pass from entry 0.
REQ-034 Start pulsed repeatedly while Busy=1 -> ignored, and the pass completes normally; Start in DONE -> a full re-run.
